dma_read_scheduler: RTL

//  Splits one DMA read transfer (base address, length in words) into burst read requests.

---
 rtl/dma_read_scheduler_if.sv | 16 +
 rtl/dma_read_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dma_read_scheduler_if.sv
// Read-request channel between the DMA read scheduler and the memory read port.
//   master : drives req_valid, req_addr, req_len; samples req_ready
//   slave  : samples req_valid, req_addr, req_len; drives req_ready
// A request is accepted on a cycle where req_valid and req_ready are both high.
interface dma_read_scheduler_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int REQ_LEN_W  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [REQ_LEN_W-1:0]  req_len;

  modport master (output req_valid, output req_addr, output req_len, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_len, output req_ready);
endinterface

// File: rtl/dma_read_scheduler.sv
// DMA read scheduler: splits one read transfer (byte base address, length in words)
// into burst read requests that never cross a BOUNDARY_BYTES address boundary and
// never reserve more data-FIFO space than is free, tracked by a credit counter.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start                transfer start pulse, only honoured while idle
//   i_base_addr            word-aligned start byte address
//   i_len_words            transfer length in words (0 completes immediately)
//   o_busy / o_done        busy outside idle / one-cycle completion pulse
//   req_if (master)        read-request channel: valid, ready, addr, len
//   i_beat_valid           one read word written into the data FIFO
//   i_fifo_rd_en           consumer pop from the data FIFO, returns one credit
//   o_credit               free FIFO words not yet reserved by a request
//   o_err                  sticky protocol error flag
module dma_read_scheduler #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int BURST_WORDS     = 16,
  parameter int WORD_BYTES      = 4,
  parameter int BOUNDARY_BYTES  = 4096,
  parameter int FIFO_BITS_DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDR_WIDTH-1:0]    i_base_addr,
  input  logic [LEN_WIDTH-1:0]     i_len_words,
  output logic                     o_busy,
  output logic                     o_done,
  dma_read_scheduler_if.master     req_if,
  input  logic                     i_beat_valid,
  input  logic                     i_fifo_rd_en,
  output logic [FIFO_BITS_DEPTH:0] o_credit,
  output logic                     o_err
);
  localparam int REQ_LEN_W = $clog2(BURST_WORDS) + 1;
  localparam int CREDIT_W  = FIFO_BITS_DEPTH + 1;
  localparam int BOFF_W    = $clog2(BOUNDARY_BYTES);
  localparam int WB_SHIFT  = $clog2(WORD_BYTES);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(1) << FIFO_BITS_DEPTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] reqAddr_q, reqAddr_d;
  logic [REQ_LEN_W-1:0]  reqLen_q, reqLen_d;
  logic                  err_q, err_d;

  logic                  handshake;
  logic [CREDIT_W-1:0]   creditAfterIssue;
  logic [ADDR_WIDTH-1:0] nextAddr;
  logic [LEN_WIDTH-1:0]  nextRemain;
  logic [REQ_LEN_W-1:0]  curBurst, nextBurst;

  // Burst length for a given in-boundary byte offset and remaining word count:
  // the smallest of remaining words, the burst limit and the words left before
  // the next boundary.
  function automatic logic [REQ_LEN_W-1:0] burstLen(input logic [BOFF_W-1:0] offset,
                                                    input logic [LEN_WIDTH-1:0] rem);
    logic [31:0] toBoundary;
    logic [31:0] len;
    toBoundary = (32'(BOUNDARY_BYTES) - 32'(offset)) >> WB_SHIFT;
    len = 32'(rem);
    if (len > 32'(BURST_WORDS)) len = 32'(BURST_WORDS);
    if (len > toBoundary) len = toBoundary;
    return REQ_LEN_W'(len);
  endfunction

  // State registers; reset drops any transfer in flight and restores full credit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      len_q     <= '0;
      beats_q   <= '0;
      credit_q  <= CREDIT_MAX;
      valid_q   <= 1'b0;
      reqAddr_q <= '0;
      reqLen_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      len_q     <= len_d;
      beats_q   <= beats_d;
      credit_q  <= credit_d;
      valid_q   <= valid_d;
      reqAddr_q <= reqAddr_d;
      reqLen_q  <= reqLen_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: credit bookkeeping, beat counting, then the transfer FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    len_d     = len_q;
    beats_d   = beats_q;
    valid_d   = valid_q;
    reqAddr_d = reqAddr_q;
    reqLen_d  = reqLen_q;
    err_d     = err_q;

    handshake  = valid_q & req_if.req_ready;
    nextAddr   = addr_q + (ADDR_WIDTH'(reqLen_q) << WB_SHIFT);
    nextRemain = remain_q - LEN_WIDTH'(reqLen_q);
    curBurst   = burstLen(addr_q[BOFF_W-1:0], remain_q);
    nextBurst  = burstLen(nextAddr[BOFF_W-1:0], nextRemain);

    // An accepted request and a pop in the same cycle both apply; a pop that
    // would return credit nobody reserved is an error and is dropped.
    creditAfterIssue = credit_q - (handshake ? CREDIT_W'(reqLen_q) : '0);
    credit_d = creditAfterIssue;
    if (i_fifo_rd_en) begin
      if (creditAfterIssue >= CREDIT_MAX) err_d = 1'b1;
      else credit_d = creditAfterIssue + CREDIT_W'(1);
    end

    // Beats only belong to a transfer while issuing or waiting for data; any
    // beat past the transfer length is an error and is not counted.
    if (i_beat_valid) begin
      if ((state_q == ISSUE || state_q == WAIT_DATA) && beats_q != len_q)
        beats_d = beats_q + LEN_WIDTH'(1);
      else
        err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len_words != '0) begin
            addr_d   = i_base_addr;
            remain_d = i_len_words;
            len_d    = i_len_words;
            beats_d  = '0;
            state_d  = ISSUE;
          end else begin
            state_d  = DONE;
          end
        end
      end
      ISSUE: begin
        if (handshake) begin
          addr_d   = nextAddr;
          remain_d = nextRemain;
          if (nextRemain == '0) begin
            valid_d = 1'b0;
            state_d = WAIT_DATA;
          end else if (credit_d >= CREDIT_W'(nextBurst)) begin
            // Enough credit left after this acceptance: present the next burst back-to-back.
            valid_d   = 1'b1;
            reqAddr_d = nextAddr;
            reqLen_d  = nextBurst;
          end else begin
            valid_d = 1'b0;
          end
        end else if (!valid_q && credit_q >= CREDIT_W'(curBurst)) begin
          valid_d   = 1'b1;
          reqAddr_d = addr_q;
          reqLen_d  = curBurst;
        end
      end
      WAIT_DATA: begin
        if (beats_d == len_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy           = (state_q != IDLE);
  assign o_done           = (state_q == DONE);
  assign o_credit         = credit_q;
  assign o_err            = err_q;
  assign req_if.req_valid = valid_q;
  assign req_if.req_addr  = reqAddr_q;
  assign req_if.req_len   = reqLen_q;

endmodule
